// File: rtl/mem_access_seq_r0.sv
// MEM-stage access sequencer: one req/ack transaction per byte-lane access against a
// variable-latency data memory, with pipeline stall, load alignment and an abort watchdog.
module mem_access_seq_r0 #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mem_read,
  input  logic [3:0]        mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              dmem_req,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_we,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              timeout_err
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-3:0]   r_addr;
  logic [3:0]          r_rd;
  logic [3:0]          r_wr;
  logic [31:0]         r_wdata;
  logic [7:0]          r_wdog;
  logic [31:0]         r_load_data;
  logic                r_timeout_err;
  logic                w_access;
  logic [7:0]          w_wdog_inc;
  logic                w_expire;
  logic [31:0]         w_aligned;
  logic [1:0]          w_unused_addr_lsb;

  assign w_access          = (|mem_read) | (|mem_write);
  assign w_wdog_inc        = r_wdog + 8'd1;
  assign w_expire          = (w_wdog_inc == 8'(TIMEOUT));
  assign w_unused_addr_lsb = addr[1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; an ack in the expiry cycle still completes normally
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_access) w_state_nxt = StReq;
      StReq:   if (dmem_ack || w_expire) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Right-align and zero-extend the selected lanes; unsupported masks read as zero
  always_comb begin
    w_aligned = 32'd0;
    case (r_rd)
      4'b0001: w_aligned = {24'd0, dmem_rdata[7:0]};
      4'b0010: w_aligned = {24'd0, dmem_rdata[15:8]};
      4'b0100: w_aligned = {24'd0, dmem_rdata[23:16]};
      4'b1000: w_aligned = {24'd0, dmem_rdata[31:24]};
      4'b0011: w_aligned = {16'd0, dmem_rdata[15:0]};
      4'b0110: w_aligned = {16'd0, dmem_rdata[23:8]};
      4'b1100: w_aligned = {16'd0, dmem_rdata[31:16]};
      4'b1111: w_aligned = dmem_rdata;
      default: w_aligned = 32'd0;
    endcase
  end

  // Request registers, watchdog and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr        <= '0;
      r_rd          <= 4'd0;
      r_wr          <= 4'd0;
      r_wdata       <= 32'd0;
      r_wdog        <= 8'd0;
      r_load_data   <= 32'd0;
      r_timeout_err <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_access) begin
            r_addr  <= addr[ADDR_W-1:2];
            r_rd    <= mem_read;
            r_wr    <= mem_write;
            r_wdata <= store_data;
            r_wdog  <= 8'd0;
          end
        end
        StReq: begin
          r_wdog <= w_wdog_inc;
          if (dmem_ack) begin
            if (|r_rd) r_load_data <= w_aligned;
          end else if (w_expire) begin
            r_load_data   <= 32'd0;
            r_timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs; reads take priority so write strobes are suppressed when any read lane is set
  always_comb begin
    dmem_req   = (r_state == StReq);
    dmem_addr  = {r_addr, 2'b00};
    dmem_wdata = r_wdata;
    dmem_we    = ((r_state == StReq) && (r_rd == 4'd0)) ? r_wr : 4'd0;
    stall      = ((r_state == StIdle) && w_access) || (r_state == StReq);
    load_valid = (r_state == StDone) && (|r_rd);
    load_data  = r_load_data;
    timeout_err = r_timeout_err;
  end

endmodule
